mem_port_arbiter: RTL and testbench

Two-requester arbiter for the single-ported main memory, letting the stage-three data access path and the instruction-fetch path share one memory. Each cycle it grants at most one access and drives the memory address, write-enable and write-data lines. It routes the registered read data back to whichever requester issued the read. Data accesses have priority, and a starvation counter guarantees fetch forward progress. The block sits between the pipeline stages and `mem_main`.

---
 rtl/mem_port_arbiter.sv | 117 +++++++++++
 tb/tb_mem_port_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the data-access
// path and the instruction-fetch path. Data normally wins. A starvation
// counter forces a fetch grant after STARVE_LIMIT consecutive denied cycles.
// Read data is returned to the requester that issued the read.
module mem_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 3
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        halt_sys_i,
   input  logic        d_req_i,
   input  logic        d_we_i,
   input  logic [15:0] d_addr_i,
   input  logic [15:0] d_wdata_i,
   output logic        d_gnt_o,
   output logic        d_rvalid_o,
   output logic [15:0] d_rdata_o,
   input  logic        f_req_i,
   input  logic [15:0] f_addr_i,
   output logic        f_gnt_o,
   output logic        f_rvalid_o,
   output logic [15:0] f_rdata_o,
   output logic        mem_write_en_o,
   output logic [15:0] mem_address_o,
   output logic [15:0] mem_write_data_o,
   input  logic [15:0] mem_data_out_i,
   output logic        starved_o
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0] starve_cnt_q;
   logic [3:0] starve_cnt_d;
   logic       rd_pend_d_q;
   logic       rd_pend_f_q;
   logic       d_gnt_s;
   logic       f_gnt_s;
   logic       starved_s;

   assign starved_s = (starve_cnt_q == LIMIT);

   // Fixed-priority grant with starvation override; nothing is granted in reset or halt.
   always_comb begin
      d_gnt_s = 1'b0;
      f_gnt_s = 1'b0;
      if (rst_i || halt_sys_i) begin
         d_gnt_s = 1'b0;
         f_gnt_s = 1'b0;
      end else if (f_req_i && starved_s) begin
         f_gnt_s = 1'b1;
      end else if (d_req_i) begin
         d_gnt_s = 1'b1;
      end else if (f_req_i) begin
         f_gnt_s = 1'b1;
      end else begin
         d_gnt_s = 1'b0;
         f_gnt_s = 1'b0;
      end
   end

   // Memory port mux: the granted requester drives the memory; idle drives zeros.
   always_comb begin
      mem_write_en_o   = 1'b0;
      mem_address_o    = 16'h0000;
      mem_write_data_o = 16'h0000;
      if (d_gnt_s) begin
         mem_write_en_o   = d_we_i;
         mem_address_o    = d_addr_i;
         mem_write_data_o = d_wdata_i;
      end else if (f_gnt_s) begin
         mem_write_en_o   = 1'b0;
         mem_address_o    = f_addr_i;
         mem_write_data_o = 16'h0000;
      end else begin
         mem_write_en_o   = 1'b0;
         mem_address_o    = 16'h0000;
         mem_write_data_o = 16'h0000;
      end
   end

   // Starvation counter next state: clears once fetch is served or stops asking,
   // freezes during halt, otherwise counts denied cycles up to the limit.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!f_req_i || f_gnt_s) begin
         starve_cnt_d = 4'd0;
      end else if (halt_sys_i) begin
         starve_cnt_d = starve_cnt_q;
      end else if (starve_cnt_q < LIMIT) begin
         starve_cnt_d = starve_cnt_q + 4'd1;
      end else begin
         starve_cnt_d = starve_cnt_q;
      end
   end

   // State registers: counter and which requester owns the read returning next cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         starve_cnt_q <= 4'd0;
         rd_pend_d_q  <= 1'b0;
         rd_pend_f_q  <= 1'b0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         rd_pend_d_q  <= d_gnt_s & ~d_we_i;
         rd_pend_f_q  <= f_gnt_s;
      end
   end

   assign d_gnt_o    = d_gnt_s;
   assign f_gnt_o    = f_gnt_s;
   assign starved_o  = starved_s;
   assign d_rvalid_o = rd_pend_d_q;
   assign f_rvalid_o = rd_pend_f_q;
   assign d_rdata_o  = rd_pend_d_q ? mem_data_out_i : 16'h0000;
   assign f_rdata_o  = rd_pend_f_q ? mem_data_out_i : 16'h0000;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: a behavioural single-port memory with one
// cycle read latency, directed stimulus, and a queue of expected read returns.
module tb_mem_port_arbiter;

   logic        clk;
   logic        rst;
   logic        halt_sys;
   logic        d_req, d_we;
   logic [15:0] d_addr, d_wdata;
   logic        d_gnt, d_rvalid;
   logic [15:0] d_rdata;
   logic        f_req;
   logic [15:0] f_addr;
   logic        f_gnt, f_rvalid;
   logic [15:0] f_rdata;
   logic        mem_we;
   logic [15:0] mem_addr, mem_wdata, mem_rd;
   logic        starved;

   typedef struct {
      int          cyc;
      bit          is_f;
      logic [15:0] data;
   } exp_t;

   exp_t sb[$];
   int   cyc   = 0;
   int   tests = 0;
   int   fails = 0;

   logic [15:0] mem [0:65535];

   mem_port_arbiter #(.STARVE_LIMIT(3)) dut (
      .clk_i(clk), .rst_i(rst), .halt_sys_i(halt_sys),
      .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
      .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
      .f_req_i(f_req), .f_addr_i(f_addr),
      .f_gnt_o(f_gnt), .f_rvalid_o(f_rvalid), .f_rdata_o(f_rdata),
      .mem_write_en_o(mem_we), .mem_address_o(mem_addr),
      .mem_write_data_o(mem_wdata), .mem_data_out_i(mem_rd),
      .starved_o(starved)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single-port memory: write at the edge, registered read of the presented address.
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rd <= mem[mem_addr];
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
      tests++;
      assert (obs === exp_v) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp_v, cyc);
      end
   endtask

   task automatic check_rv();
      logic        e_dv = 1'b0;
      logic        e_fv = 1'b0;
      logic [15:0] e_dd = 16'h0000;
      logic [15:0] e_fd = 16'h0000;
      exp_t        e;
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
         e = sb.pop_front();
         if (e.is_f) begin
            e_fv = 1'b1;
            e_fd = e.data;
         end else begin
            e_dv = 1'b1;
            e_dd = e.data;
         end
      end
      chk("d_rvalid", {15'd0, d_rvalid}, {15'd0, e_dv});
      chk("d_rdata", d_rdata, e_dd);
      chk("f_rvalid", {15'd0, f_rvalid}, {15'd0, e_fv});
      chk("f_rdata", f_rdata, e_fd);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      check_rv();
   endtask

   task automatic drive(input logic dr, input logic we, input logic [15:0] da,
                        input logic [15:0] dw, input logic fr, input logic [15:0] fa,
                        input logic h);
      d_req = dr; d_we = we; d_addr = da; d_wdata = dw;
      f_req = fr; f_addr = fa; halt_sys = h;
      #1;
   endtask

   task automatic chk_gnt(input string tag, input logic eg_d, input logic eg_f);
      chk({tag, "_d_gnt"}, {15'd0, d_gnt}, {15'd0, eg_d});
      chk({tag, "_f_gnt"}, {15'd0, f_gnt}, {15'd0, eg_f});
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b1, 1'b1, 16'h0005, 16'h1111, 1'b0, 16'h0000, 1'b0);
      #1;
      chk_gnt("rst_hold", 1'b0, 1'b0);
      chk("rst_mem_we", {15'd0, mem_we}, 16'h0000);
      chk("rst_mem_addr", mem_addr, 16'h0000);
      chk("rst_d_rvalid", {15'd0, d_rvalid}, 16'h0000);
      chk("rst_starved", {15'd0, starved}, 16'h0000);
      tick();
      tick();
      rst = 1'b0;
      drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
      chk("post_rst_starved", {15'd0, starved}, 16'h0000);

      // Asynchronous reset between edges with a data request pending.
      drive(1'b1, 1'b1, 16'h0020, 16'hDEAD, 1'b0, 16'h0000, 1'b0);
      chk_gnt("pre_async", 1'b1, 1'b0);
      rst = 1'b1;
      #1;
      chk_gnt("async_rst", 1'b0, 1'b0);
      chk("async_mem_we", {15'd0, mem_we}, 16'h0000);
      chk("async_d_rvalid", {15'd0, d_rvalid}, 16'h0000);
      tick();
      rst = 1'b0;
      drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
      tick();

      // Preload through the data port.
      drive(1'b1, 1'b1, 16'h0004, 16'h1234, 1'b0, 16'h0000, 1'b0);
      chk_gnt("pre1", 1'b1, 1'b0);
      tick();
      drive(1'b1, 1'b1, 16'h0008, 16'h5678, 1'b0, 16'h0000, 1'b0);
      tick();
      drive(1'b1, 1'b1, 16'h0030, 16'hA5A5, 1'b0, 16'h0000, 1'b0);
      tick();

      // Data write then read-after-write of the same address.
      drive(1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000, 1'b0);
      chk_gnt("wr", 1'b1, 1'b0);
      chk("wr_mem_we", {15'd0, mem_we}, 16'h0001);
      chk("wr_mem_addr", mem_addr, 16'h0010);
      chk("wr_mem_wdata", mem_wdata, 16'hBEEF);
      tick();
      drive(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000, 1'b0);
      sb.push_back('{cyc + 1, 1'b0, 16'hBEEF});
      chk_gnt("rd", 1'b1, 1'b0);
      chk("rd_mem_we", {15'd0, mem_we}, 16'h0000);
      chk("rd_mem_addr", mem_addr, 16'h0010);
      tick();
      drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
      chk_gnt("idle", 1'b0, 1'b0);
      chk("idle_mem_addr", mem_addr, 16'h0000);
      chk("idle_mem_we", {15'd0, mem_we}, 16'h0000);
      tick();

      // Fetch alone; data write fields must not leak onto the memory port.
      drive(1'b0, 1'b1, 16'h0077, 16'hFFFF, 1'b1, 16'h0004, 1'b0);
      sb.push_back('{cyc + 1, 1'b1, 16'h1234});
      chk_gnt("fetch", 1'b0, 1'b1);
      chk("fetch_mem_addr", mem_addr, 16'h0004);
      chk("fetch_mem_we", {15'd0, mem_we}, 16'h0000);
      chk("fetch_mem_wdata", mem_wdata, 16'h0000);
      tick();
      drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
      tick();

      // Continuous contention: D,D,D,F repeating, starved on each F cycle.
      for (int i = 0; i < 8; i++) begin
         logic ef;
         ef = ((i % 4) == 3);
         drive(1'b1, 1'b0, 16'h0030, 16'h0000, 1'b1, 16'h0008, 1'b0);
         sb.push_back('{cyc + 1, ef, ef ? 16'h5678 : 16'hA5A5});
         chk_gnt($sformatf("cont%0d", i), ~ef, ef);
         chk($sformatf("cont%0d_starved", i), {15'd0, starved}, {15'd0, ef});
         tick();
      end
      drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
      tick();

      // Halt after a data-read grant: return still delivered, counter frozen.
      drive(1'b1, 1'b0, 16'h0030, 16'h0000, 1'b1, 16'h0008, 1'b0);
      sb.push_back('{cyc + 1, 1'b0, 16'hA5A5});
      chk_gnt("pre_halt", 1'b1, 1'b0);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 16'h0030, 16'h0000, 1'b1, 16'h0008, 1'b1);
         chk_gnt($sformatf("halt%0d", i), 1'b0, 1'b0);
         chk($sformatf("halt%0d_mem_we", i), {15'd0, mem_we}, 16'h0000);
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         logic ef;
         ef = (i == 2);
         drive(1'b1, 1'b0, 16'h0030, 16'h0000, 1'b1, 16'h0008, 1'b0);
         sb.push_back('{cyc + 1, ef, ef ? 16'h5678 : 16'hA5A5});
         chk_gnt($sformatf("resume%0d", i), ~ef, ef);
         tick();
      end
      drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
      tick();

      // Reset in the cycle after a fetch grant: that return is dropped.
      drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0004, 1'b0);
      chk_gnt("pre_rst_rd", 1'b0, 1'b1);
      @(posedge clk);
      rst = 1'b1;
      #1;
      cyc++;
      check_rv();
      drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
      tick();
      rst = 1'b0;
      tick();

      chk("scoreboard_empty", 16'(sb.size()), 16'h0000);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
